hdr_stream_gen: RTL and testbench

- Parametrised Ethernet/IPv4/UDP frame header generator with payload insertion.
- On start, latches the address/port configuration and a payload word of N_PAY bytes.
- Optionally computes the IPv4 header checksum over several cycles.
- Streams the frame out one byte per cycle on a valid/ready interface to the MAC transmit path. Length, ID and checksum fields are generated per frame; no fixed template is used.

---
 rtl/hdr_stream_gen.sv | 188 ++++++++++++++++++
 tb/tb_hdr_stream_gen.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_stream_gen.sv
// Ethernet/IPv4/UDP header generator with payload insertion, one byte per cycle.
// Define IP_CSUM_EN to compute the IPv4 header checksum; otherwise bytes 24-25 are zero.
module hdr_stream_gen #(
  parameter int          N_PAY   = 8,
  parameter logic [15:0] ID_INIT = 16'h0000,
  parameter logic [7:0]  TTL     = 8'h40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [47:0]        cfg_dst_mac,
  input  logic [47:0]        cfg_src_mac,
  input  logic [31:0]        cfg_src_ip,
  input  logic [31:0]        cfg_dst_ip,
  input  logic [15:0]        cfg_src_port,
  input  logic [15:0]        cfg_dst_port,
  input  logic [8*N_PAY-1:0] payload_in,
  output logic               busy,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sop,
  output logic               out_eop
);

  localparam int          NB       = 42 + N_PAY;
  localparam int          FW       = 8 * NB;
  localparam logic [6:0]  LAST_IDX = 7'(NB - 1);
  localparam logic [15:0] TOTLEN   = 16'(28 + N_PAY);
  localparam logic [15:0] UDPLEN   = 16'(8 + N_PAY);

`ifdef IP_CSUM_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_FOLD = 2'd2, ST_SEND = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1} state_t;
`endif

  state_t             state_q;
  logic [47:0]        dst_mac_q, src_mac_q;
  logic [31:0]        src_ip_q, dst_ip_q;
  logic [15:0]        src_port_q, dst_port_q;
  logic [8*N_PAY-1:0] pay_q;
  logic [15:0]        id_q;
  logic [6:0]         idx_q;
  logic [7:0]         out_data_q;
  logic               busy_q, out_valid_q, out_sop_q, out_eop_q;
  logic [15:0]        csum_s;
  logic [FW-1:0]      frame_s;
  logic [6:0]         next_idx_d;
  logic [7:0]         next_byte_d;

`ifdef IP_CSUM_EN
  logic [31:0] acc_q;
  logic [3:0]  cnt_q;
  logic [15:0] csum_q;

  // Header words summed in CALC, one per cycle, checksum field taken as zero.
  function automatic logic [15:0] hdr_word(input logic [3:0] k, input logic [15:0] id,
                                           input logic [31:0] sip, input logic [31:0] dip);
    case (k)
      4'd0:    return 16'h4500;
      4'd1:    return TOTLEN;
      4'd2:    return id;
      4'd3:    return 16'h4000;
      4'd4:    return {TTL, 8'h11};
      4'd5:    return 16'h0000;
      4'd6:    return sip[31:16];
      4'd7:    return sip[15:0];
      4'd8:    return dip[31:16];
      4'd9:    return dip[15:0];
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] csum_fold(input logic [31:0] acc);
    logic [16:0] s;
    s = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
    s = {1'b0, s[15:0]} + {16'h0000, s[16]};
    return ~s[15:0];
  endfunction

  assign csum_s = csum_q;
`else
  assign csum_s = 16'h0000;
`endif

  assign frame_s = {dst_mac_q, src_mac_q, 16'h0800, 8'h45, 8'h00, TOTLEN, id_q, 16'h4000,
                    TTL, 8'h11, csum_s, src_ip_q, dst_ip_q, src_port_q, dst_port_q,
                    UDPLEN, 16'h0000, pay_q};

  assign busy      = busy_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;

  // Byte to present next: index 0 on the first SEND cycle, else the successor.
  always_comb begin
    next_idx_d  = 7'd0;
    next_byte_d = 8'h00;
    if (out_valid_q) begin
      next_idx_d = idx_q + 7'd1;
    end else begin
      next_idx_d = 7'd0;
    end
    if (next_idx_d <= LAST_IDX) begin
      next_byte_d = frame_s[FW - 8 - 8 * int'(next_idx_d) +: 8];
    end else begin
      next_byte_d = 8'h00;
    end
  end

  // Frame sequencer with registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= 8'h00;
      id_q        <= ID_INIT;
      idx_q       <= 7'd0;
`ifdef IP_CSUM_EN
      acc_q       <= 32'h0000_0000;
      cnt_q       <= 4'd0;
      csum_q      <= 16'h0000;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dst_mac_q  <= cfg_dst_mac;
            src_mac_q  <= cfg_src_mac;
            src_ip_q   <= cfg_src_ip;
            dst_ip_q   <= cfg_dst_ip;
            src_port_q <= cfg_src_port;
            dst_port_q <= cfg_dst_port;
            pay_q      <= payload_in;
            busy_q     <= 1'b1;
            idx_q      <= 7'd0;
`ifdef IP_CSUM_EN
            acc_q      <= 32'h0000_0000;
            cnt_q      <= 4'd0;
            state_q    <= ST_CALC;
`else
            state_q    <= ST_SEND;
`endif
          end
        end
`ifdef IP_CSUM_EN
        ST_CALC: begin
          acc_q <= acc_q + {16'h0000, hdr_word(cnt_q, id_q, src_ip_q, dst_ip_q)};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd9) begin
            state_q <= ST_FOLD;
          end
        end
        ST_FOLD: begin
          csum_q  <= csum_fold(acc_q);
          state_q <= ST_SEND;
        end
`endif
        ST_SEND: begin
          // First SEND cycle loads byte 0; afterwards advance only on transfer.
          if (!out_valid_q || out_ready) begin
            if (out_valid_q && out_eop_q) begin
              out_valid_q <= 1'b0;
              out_sop_q   <= 1'b0;
              out_eop_q   <= 1'b0;
              busy_q      <= 1'b0;
              id_q        <= id_q + 16'd1;
              state_q     <= ST_IDLE;
            end else begin
              out_valid_q <= 1'b1;
              out_data_q  <= next_byte_d;
              out_sop_q   <= (next_idx_d == 7'd0);
              out_eop_q   <= (next_idx_d == LAST_IDX);
              idx_q       <= next_idx_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdr_stream_gen.sv
// Self-checking bench for hdr_stream_gen: frame-level reference model plus literal pins.
module tb_hdr_stream_gen;

  localparam int N_PAY = 8;
  localparam int NB    = 42 + N_PAY;
`ifdef IP_CSUM_EN
  localparam int          LAT = 12;
  localparam logic [15:0] CS1 = 16'h32B8;
  localparam logic [15:0] CS2 = 16'h32B7;
`else
  localparam int          LAT = 1;
  localparam logic [15:0] CS1 = 16'h0000;
  localparam logic [15:0] CS2 = 16'h0000;
`endif

  logic               clk = 1'b0;
  logic               rst, start, start_w, out_ready;
  logic [47:0]        cfg_dst_mac, cfg_src_mac;
  logic [31:0]        cfg_src_ip, cfg_dst_ip;
  logic [15:0]        cfg_src_port, cfg_dst_port;
  logic [8*N_PAY-1:0] payload_in;
  logic               busy, out_valid, out_sop, out_eop;
  logic [7:0]         out_data;
  logic               w_busy, w_valid, w_sop, w_eop;
  logic [7:0]         w_data;

  always #5 clk = ~clk;

  hdr_stream_gen #(.N_PAY(N_PAY)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac),
    .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
    .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
    .payload_in(payload_in), .busy(busy), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop)
  );

  hdr_stream_gen #(.N_PAY(N_PAY), .ID_INIT(16'hFFFF)) u_wrap (
    .clk(clk), .rst(rst), .start(start_w),
    .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac),
    .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
    .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
    .payload_in(payload_in), .busy(w_busy), .out_data(w_data),
    .out_valid(w_valid), .out_ready(1'b1), .out_sop(w_sop), .out_eop(w_eop)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_id = 16'h0000;
  logic [7:0]  exp_fr[NB];
  logic [7:0]  cap[NB];
  logic [7:0]  last_frame[NB];
  logic [7:0]  s1_frame[NB];
  int          frames = 0;
  int          transfers = 0;
  int          lat_obs = -1;
  bit          seen_v = 1'b0;
  bit          stall_p = 1'b0;
  logic [7:0]  p_data;
  logic        p_sop, p_eop;

  // Whole frame from field definitions; checksum is the standard one's-complement sum.
  task automatic build_frame(input logic [15:0] id);
    logic [15:0] tl, ul, cs;
    int unsigned s;
    tl = 16'(28 + N_PAY);
    ul = 16'(8 + N_PAY);
    for (int k = 0; k < 6; k++) begin
      exp_fr[k]     = cfg_dst_mac[8*(5-k) +: 8];
      exp_fr[6 + k] = cfg_src_mac[8*(5-k) +: 8];
    end
    exp_fr[12] = 8'h08; exp_fr[13] = 8'h00; exp_fr[14] = 8'h45; exp_fr[15] = 8'h00;
    exp_fr[16] = tl[15:8]; exp_fr[17] = tl[7:0];
    exp_fr[18] = id[15:8]; exp_fr[19] = id[7:0];
    exp_fr[20] = 8'h40; exp_fr[21] = 8'h00; exp_fr[22] = 8'h40; exp_fr[23] = 8'h11;
    exp_fr[24] = 8'h00; exp_fr[25] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      exp_fr[26 + k] = cfg_src_ip[8*(3-k) +: 8];
      exp_fr[30 + k] = cfg_dst_ip[8*(3-k) +: 8];
    end
    exp_fr[34] = cfg_src_port[15:8]; exp_fr[35] = cfg_src_port[7:0];
    exp_fr[36] = cfg_dst_port[15:8]; exp_fr[37] = cfg_dst_port[7:0];
    exp_fr[38] = ul[15:8]; exp_fr[39] = ul[7:0];
    exp_fr[40] = 8'h00; exp_fr[41] = 8'h00;
    for (int k = 0; k < N_PAY; k++) exp_fr[42 + k] = payload_in[8*(N_PAY-1-k) +: 8];
    s = 0;
    for (int k = 14; k < 34; k += 2) s += {16'h0000, exp_fr[k], exp_fr[k+1]};
    while (s > 32'h0000_FFFF) s = (s & 32'h0000_FFFF) + (s >> 16);
    cs = ~s[15:0];
`ifdef IP_CSUM_EN
    exp_fr[24] = cs[15:8]; exp_fr[25] = cs[7:0];
`else
    if (cs == 16'h0000) exp_fr[24] = 8'h00;
`endif
  endtask

  // Compare process: check current outputs, then advance the model across the next edge.
  always @(negedge clk) begin
    bit ev;
    ev = m_busy && (m_cnt >= LAT);
    chk("busy", {63'd0, busy}, {63'd0, m_busy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
    if (ev && out_valid) begin
      chk($sformatf("data[%0d]", m_idx), {56'd0, out_data}, {56'd0, exp_fr[m_idx]});
      chk("sop", {63'd0, out_sop}, {63'd0, m_idx == 0});
      chk("eop", {63'd0, out_eop}, {63'd0, m_idx == NB - 1});
    end
    if (stall_p && out_valid) begin
      chk("stall_data", {54'd0, out_data, out_sop, out_eop}, {54'd0, p_data, p_sop, p_eop});
    end
    if (m_busy && out_valid && !seen_v) begin
      lat_obs = m_cnt;
      seen_v  = 1'b1;
    end
    stall_p = out_valid && !out_ready && !rst;
    p_data  = out_data; p_sop = out_sop; p_eop = out_eop;
    if (rst) begin
      m_busy = 1'b0; m_id = 16'h0000; m_idx = 0; m_cnt = 0;
    end else if (m_busy) begin
      if (ev && out_ready) begin
        cap[m_idx] = out_data;
        transfers++;
        if (m_idx == NB - 1) begin
          last_frame = cap;
          m_busy = 1'b0; m_id = m_id + 16'd1; frames++; m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      m_cnt++;
    end else if (start) begin
      build_frame(m_id);
      m_busy = 1'b1; m_cnt = 0; m_idx = 0; seen_v = 1'b0;
    end
  end

  // Id-field capture for the wrap instance
  int         w_idx = 0;
  int         w_fr = 0;
  logic [7:0] w_hi[2], w_lo[2];
  always @(negedge clk) begin
    if (rst) begin
      w_idx = 0;
    end else if (w_valid) begin
      if (w_fr < 2 && w_idx == 18) w_hi[w_fr] = w_data;
      if (w_fr < 2 && w_idx == 19) w_lo[w_fr] = w_data;
      if (w_eop) begin w_fr++; w_idx = 0; end
      else w_idx++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg();
    cfg_dst_mac  = 48'h001C_C098_6D10;
    cfg_src_mac  = 48'h0011_2233_4455;
    cfg_src_ip   = 32'h0102_0305;
    cfg_dst_ip   = 32'h0102_0309;
    cfg_src_port = 16'hD6D8;
    cfg_dst_port = 16'hD6D9;
    payload_in   = 64'h0102_0304_0506_0708;
  endtask

  task automatic rand_cfg();
    cfg_dst_mac  = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    cfg_src_mac  = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    cfg_src_ip   = $urandom();
    cfg_dst_ip   = $urandom();
    cfg_src_port = 16'($urandom());
    cfg_dst_port = 16'($urandom());
    payload_in   = {$urandom(), $urandom()};
  endtask

  task automatic run_frame(input bit rnd, input bit pulse);
    int tgt;
    tgt = frames + 1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    if (rnd) rand_cfg();
    for (int i = 0; i < 3000 && frames < tgt; i++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pulse) begin
        start = 1'($urandom_range(0, 1));
        if (out_valid && out_eop && out_ready) start = 1'b1;
      end
      cyc(1);
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("frame_done", {63'd0, frames >= tgt}, 64'd1);
  endtask

  initial begin
    int f0, t0;
    rst = 1'b1; start = 1'b0; start_w = 1'b0; out_ready = 1'b1;
    set_cfg();
    cyc(3);
    rst = 1'b0;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sop_eop", {62'd0, out_sop, out_eop}, 64'd0);
    chk("rst_data", {56'd0, out_data}, 64'd0);
    cyc(2);

    // Basic frame
    t0 = transfers;
    run_frame(1'b0, 1'b0);
    chk("latency", lat_obs, LAT);
    chk("transfers1", transfers - t0, NB);
    chk("totlen", {48'd0, last_frame[16], last_frame[17]}, 64'h0024);
    chk("id1", {48'd0, last_frame[18], last_frame[19]}, 64'h0000);
    chk("csum1", {48'd0, last_frame[24], last_frame[25]}, {48'd0, CS1});
    chk("udplen", {48'd0, last_frame[38], last_frame[39]}, 64'h0010);
    chk("dmac0_5", {48'd0, last_frame[0], last_frame[5]}, 64'h0010);
    for (int k = 0; k < N_PAY; k++) chk("payload", {56'd0, last_frame[42 + k]}, 64'(k + 1));
    s1_frame = last_frame;

    // Second frame, back-to-back
    run_frame(1'b0, 1'b0);
    chk("id2", {48'd0, last_frame[18], last_frame[19]}, 64'h0001);
    chk("csum2", {48'd0, last_frame[24], last_frame[25]}, {48'd0, CS2});

    // Backpressure after reset: identical byte sequence to the first frame
    rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);
    set_cfg();
    t0 = transfers;
    run_frame(1'b1, 1'b0);
    chk("bp_transfers", transfers - t0, NB);
    begin
      int mism;
      mism = 0;
      for (int k = 0; k < NB; k++) if (last_frame[k] !== s1_frame[k]) mism++;
      chk("bp_same_bytes", mism, 0);
    end

    // start pulsed throughout busy, including the eop cycle
    set_cfg();
    f0 = frames;
    run_frame(1'b0, 1'b1);
    chk("busy_after_eop", {63'd0, busy}, 64'd0);
    cyc(20);
    chk("one_frame", frames - f0, 1);

    // Reset mid-frame at byte 20
    set_cfg();
    start = 1'b1; cyc(1); start = 1'b0;
    for (int i = 0; i < 500 && m_idx != 20; i++) cyc(1);
    chk("reached_byte20", m_idx, 20);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("abort_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    cyc(1);
    f0 = frames;
    run_frame(1'b0, 1'b0);
    chk("abort_one_frame", frames - f0, 1);
    chk("abort_id", {48'd0, last_frame[18], last_frame[19]}, 64'h0000);

    // Randomized frames with random backpressure and stray starts
    for (int r = 0; r < 4; r++) begin
      rand_cfg();
      run_frame(1'b1, 1'b1);
      cyc($urandom_range(0, 3));
    end

    // Id wrap on an instance reset to 0xFFFF
    rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);
    set_cfg();
    w_fr = 0;
    for (int f = 0; f < 2; f++) begin
      start_w = 1'b1; cyc(1); start_w = 1'b0;
      for (int i = 0; i < 500 && w_fr <= f; i++) cyc(1);
    end
    chk("wrap_frames", w_fr, 2);
    chk("wrap_id0", {48'd0, w_hi[0], w_lo[0]}, 64'hFFFF);
    chk("wrap_id1", {48'd0, w_hi[1], w_lo[1]}, 64'h0000);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
